// File: rtl/tl_tx_tag_allocator.sv
// PCIe TL requester tag allocator: round-robin tag grant, outstanding bitmap, completion retire.
// Optional per-tag completion timeout when TL_TX_TAG_CPL_TIMEOUT_EN is defined.
module tl_tx_tag_allocator #(
  parameter int REQUESTER_TAG_WIDTH = 10,
  parameter int NUM_TAGS            = 32,
  parameter int CNT_WIDTH           = 6,
  parameter int TIMEOUT_WIDTH       = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           tag_en,
  input  logic                           alloc_req,
  output logic                           alloc_gnt,
  output logic [REQUESTER_TAG_WIDTH-1:0] alloc_tag,
  input  logic                           cpl_valid,
  input  logic [REQUESTER_TAG_WIDTH-1:0] cpl_tag,
  input  logic                           cpl_last,
  output logic                           cpl_unexpected,
  input  logic [REQUESTER_TAG_WIDTH-1:0] chk_tag,
  output logic                           chk_outstanding,
  output logic [REQUESTER_TAG_WIDTH-1:0] tx_last_req_tag,
  output logic [CNT_WIDTH-1:0]           outstanding_cnt,
  output logic                           full,
  output logic                           empty,
  input  logic [TIMEOUT_WIDTH-1:0]       cpl_timeout_limit,
  output logic                           timeout_valid,
  output logic [REQUESTER_TAG_WIDTH-1:0] timeout_tag
);
  localparam int PW = $clog2(NUM_TAGS);
  localparam int TW = REQUESTER_TAG_WIDTH;
  localparam logic [NUM_TAGS-1:0] ONE = {{(NUM_TAGS-1){1'b0}}, 1'b1};

  logic [NUM_TAGS-1:0]  r_outstanding;
  logic [PW-1:0]        r_alloc_ptr;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [TW-1:0]        r_last_tag;
  logic                 r_unexp;

  logic [PW-1:0]        w_free_idx;
  logic                 w_gnt;
  logic                 w_cpl_hit;
  logic                 w_cpl_rel;
  logic                 w_chk_in_range;
  logic                 w_cpl_in_range;
  logic [NUM_TAGS-1:0]  w_set_mask;
  logic [NUM_TAGS-1:0]  w_cpl_mask;
  logic                 w_to_fire;
  logic [NUM_TAGS-1:0]  w_to_mask;

  // First clear bit at or after the pointer; descending scan lets the nearest offset win.
  always_comb begin
    w_free_idx = r_alloc_ptr;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      logic [PW-1:0] idx;
      idx = r_alloc_ptr + PW'(i);
      if (!r_outstanding[idx]) w_free_idx = idx;
    end
  end

  assign full  = (r_cnt == CNT_WIDTH'(NUM_TAGS));
  assign empty = (r_cnt == '0);
  assign w_gnt = alloc_req & tag_en & ~full & ~rst;

  assign w_cpl_in_range = ((cpl_tag >> PW) == '0);
  assign w_chk_in_range = ((chk_tag >> PW) == '0);
  assign w_cpl_hit  = cpl_valid & w_cpl_in_range & r_outstanding[cpl_tag[PW-1:0]];
  assign w_cpl_rel  = w_cpl_hit & cpl_last;
  assign w_set_mask = w_gnt ? (ONE << w_free_idx) : '0;
  assign w_cpl_mask = w_cpl_rel ? (ONE << cpl_tag[PW-1:0]) : '0;

  assign alloc_gnt       = w_gnt;
  assign alloc_tag       = TW'(w_free_idx);
  assign chk_outstanding = w_chk_in_range & r_outstanding[chk_tag[PW-1:0]];
  assign cpl_unexpected  = r_unexp;
  assign tx_last_req_tag = r_last_tag;
  assign outstanding_cnt = r_cnt;

`ifdef TL_TX_TAG_CPL_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] r_age [NUM_TAGS];
  logic                     r_to_valid;
  logic [TW-1:0]            r_to_tag;
  logic [NUM_TAGS-1:0]      w_expired;
  logic [PW-1:0]            w_to_idx;

  // A tag retired by its completion this cycle is not also reported as timed out.
  always_comb begin
    w_to_idx = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      w_expired[i] = r_outstanding[i] & (r_age[i] == cpl_timeout_limit) & ~w_cpl_mask[i];
      if (w_expired[i]) w_to_idx = PW'(i);
    end
  end

  assign w_to_fire = |w_expired;
  assign w_to_mask = w_to_fire ? (ONE << w_to_idx) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_valid <= 1'b0;
      r_to_tag   <= '0;
      for (int i = 0; i < NUM_TAGS; i++) r_age[i] <= '0;
    end else begin
      r_to_valid <= w_to_fire;
      r_to_tag   <= w_to_fire ? TW'(w_to_idx) : '0;
      for (int i = 0; i < NUM_TAGS; i++) begin
        if (w_set_mask[i])
          r_age[i] <= '0;
        else if (r_outstanding[i] && (r_age[i] != cpl_timeout_limit))
          r_age[i] <= r_age[i] + 1'b1;
      end
    end
  end

  assign timeout_valid = r_to_valid;
  assign timeout_tag   = r_to_tag;
`else
  logic w_unused_limit;
  assign w_unused_limit = ^cpl_timeout_limit;
  assign w_to_fire      = 1'b0;
  assign w_to_mask      = '0;
  assign timeout_valid  = 1'b0;
  assign timeout_tag    = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_outstanding <= '0;
      r_alloc_ptr   <= '0;
      r_cnt         <= '0;
      r_last_tag    <= '0;
      r_unexp       <= 1'b0;
    end else begin
      r_outstanding <= (r_outstanding | w_set_mask) & ~(w_cpl_mask | w_to_mask);
      r_cnt         <= r_cnt + CNT_WIDTH'(w_gnt) - CNT_WIDTH'(w_cpl_rel) - CNT_WIDTH'(w_to_fire);
      r_unexp       <= cpl_valid & ~w_cpl_hit;
      if (w_gnt) begin
        r_alloc_ptr <= w_free_idx + 1'b1;
        r_last_tag  <= TW'(w_free_idx);
      end
    end
  end
endmodule

// File: tb/tb_tl_tx_tag_allocator.sv
// Directed bench for tl_tx_tag_allocator with grant/timeout scoreboards.
// Define TL_TX_TAG_CPL_TIMEOUT_EN to also exercise the timeout path.
module tb_tl_tx_tag_allocator;
  localparam int TW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tag_en = 1'b1;
  logic          alloc_req = 1'b0;
  logic          alloc_gnt;
  logic [TW-1:0] alloc_tag;
  logic          cpl_valid = 1'b0;
  logic [TW-1:0] cpl_tag = '0;
  logic          cpl_last = 1'b0;
  logic          cpl_unexpected;
  logic [TW-1:0] chk_tag = '0;
  logic          chk_outstanding;
  logic [TW-1:0] tx_last_req_tag;
  logic [5:0]    outstanding_cnt;
  logic          full;
  logic          empty;
  logic [15:0]   cpl_timeout_limit = 16'hffff;
  logic          timeout_valid;
  logic [TW-1:0] timeout_tag;

  int n_vec = 0;
  int n_err = 0;
  int unexp_seen = 0;
  logic [TW:0]   exp_q[$];
  logic [TW-1:0] exp_to_q[$];

  tl_tx_tag_allocator dut (
    .clk(clk), .rst(rst), .tag_en(tag_en),
    .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag),
    .cpl_valid(cpl_valid), .cpl_tag(cpl_tag), .cpl_last(cpl_last),
    .cpl_unexpected(cpl_unexpected),
    .chk_tag(chk_tag), .chk_outstanding(chk_outstanding),
    .tx_last_req_tag(tx_last_req_tag), .outstanding_cnt(outstanding_cnt),
    .full(full), .empty(empty),
    .cpl_timeout_limit(cpl_timeout_limit),
    .timeout_valid(timeout_valid), .timeout_tag(timeout_tag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Grant monitor: every presented request consumes one expected {gnt, tag}.
  always @(negedge clk) begin
    if (!rst && alloc_req) begin
      if (exp_q.size() == 0) begin
        check("grant_unplanned", 1, 0);
      end else begin
        logic [TW:0] e;
        e = exp_q.pop_front();
        check("alloc_gnt", int'(alloc_gnt), int'(e[TW]));
        if (e[TW] && alloc_gnt) check("alloc_tag", int'(alloc_tag), int'(e[TW-1:0]));
      end
    end
  end

  always @(negedge clk) begin
    if (cpl_unexpected) unexp_seen++;
    if (timeout_valid) begin
      if (exp_to_q.size() == 0) check("timeout_unplanned", int'(timeout_tag), -1);
      else check("timeout_tag", int'(timeout_tag), int'(exp_to_q.pop_front()));
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic g, input int t);
    alloc_req = 1'b1;
    exp_q.push_back({g, TW'(t)});
    cycle();
    alloc_req = 1'b0;
  endtask

  task automatic cpl(input int t, input logic last);
    cpl_valid = 1'b1;
    cpl_tag   = TW'(t);
    cpl_last  = last;
    cycle();
    cpl_valid = 1'b0;
    cpl_last  = 1'b0;
  endtask

  task automatic chk(input string name, input int t, input int exp);
    chk_tag = TW'(t);
    @(negedge clk);
    check(name, int'(chk_outstanding), exp);
  endtask

  task automatic status(input int cnt, input int f, input int e);
    @(negedge clk);
    check("outstanding_cnt", int'(outstanding_cnt), cnt);
    check("full", int'(full), f);
    check("empty", int'(empty), e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state, with a request held to prove grants are blocked
    rst = 1'b1;
    alloc_req = 1'b1;
    repeat (3) cycle();
    @(negedge clk);
    check("gnt_in_reset", int'(alloc_gnt), 0);
    check("last_tag_rst", int'(tx_last_req_tag), 0);
    check("unexp_rst", int'(cpl_unexpected), 0);
    check("to_valid_rst", int'(timeout_valid), 0);
    status(0, 0, 1);
    alloc_req = 1'b0;
    rst = 1'b0;
    cycle();

    // Fill all 32 tags in order, then one more request is refused
    for (int i = 0; i < 32; i++) req(1'b1, i);
    status(32, 1, 0);
    check("last_tag_31", int'(tx_last_req_tag), 31);
    req(1'b0, 0);

    // Retire tag 5, it comes back first
    cpl(5, 1'b1);
    status(31, 0, 0);
    chk("chk5_clear", 5, 0);
    chk("chk6_set", 6, 1);
    chk("chk38_range", 38, 0);
    req(1'b1, 5);
    @(negedge clk);
    check("last_tag_5", int'(tx_last_req_tag), 5);

    // Out-of-range completion: pulse only, no state change
    cpl(38, 1'b1);
    @(negedge clk);
    check("unexp_pulse_38", int'(cpl_unexpected), 1);
    status(32, 1, 0);
    check("unexp_clears", int'(cpl_unexpected), 0);

    // Non-final then final completion on tag 7
    cpl(7, 1'b0);
    chk("chk7_partial", 7, 1);
    check("unexp_partial", int'(cpl_unexpected), 0);
    status(32, 1, 0);
    cpl(7, 1'b1);
    chk("chk7_final", 7, 0);
    check("unexp_final", int'(cpl_unexpected), 0);
    status(31, 0, 0);

    // tag_en low blocks, then search from pointer 6 finds 7
    tag_en = 1'b0;
    req(1'b0, 0);
    tag_en = 1'b1;
    req(1'b1, 7);
    // Release 2: search from 8 must wrap to reach it
    cpl(2, 1'b1);
    req(1'b1, 2);
    status(32, 1, 0);

    // Reset mid-operation drops everything
    do_reset();
    status(0, 0, 1);
    cpl(3, 1'b1);
    @(negedge clk);
    check("unexp_pulse_3", int'(cpl_unexpected), 1);
    cpl(40, 1'b0);
    @(negedge clk);
    check("unexp_pulse_40", int'(cpl_unexpected), 1);
    status(0, 0, 1);
    check("unexp_total", unexp_seen, 3);

    // Same-cycle grant and release at count 10
    for (int i = 0; i < 10; i++) req(1'b1, i);
    alloc_req = 1'b1;
    exp_q.push_back({1'b1, TW'(10)});
    cpl_valid = 1'b1;
    cpl_tag   = TW'(2);
    cpl_last  = 1'b1;
    cycle();
    alloc_req = 1'b0;
    cpl_valid = 1'b0;
    cpl_last  = 1'b0;
    status(10, 0, 0);
    check("last_tag_10", int'(tx_last_req_tag), 10);
    chk("chk2_released", 2, 0);
    chk("chk10_granted", 10, 1);
    req(1'b1, 11);
    check("unexp_none_more", unexp_seen, 3);

`ifdef TL_TX_TAG_CPL_TIMEOUT_EN
    do_reset();
    cpl_timeout_limit = 16'd100;
    exp_to_q.push_back(TW'(0));
    exp_to_q.push_back(TW'(1));
    req(1'b1, 0);
    req(1'b1, 1);
    repeat (50) cycle();
    check("to_not_early", exp_to_q.size(), 2);
    begin
      int budget;
      budget = 300;
      while (!empty && budget > 0) begin
        cycle();
        budget--;
      end
      check("to_budget", int'(budget > 0), 1);
    end
    repeat (2) cycle();
    check("to_all_seen", exp_to_q.size(), 0);
    status(0, 0, 1);
`endif

    repeat (2) cycle();
    check("grant_q_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
